// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed address/data bus sequencer: turns each Control mode into a
// framed burst of ten bus transactions (nine register accesses plus a command).
module rtc_bus_sequencer #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_PW  = 4,
  parameter int unsigned T_GAP = 8
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic [1:0] Control,
  input  logic [7:0] data_in,
  input  logic [7:0] ad_in,
  output logic [3:0] reg_idx,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ad,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] rd_data,
  output logic [3:0] rd_idx,
  output logic       rd_valid,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned MAX_SP = (T_SU > T_PW) ? T_SU : T_PW;
  localparam int unsigned MAX_T  = (MAX_SP > T_GAP) ? MAX_SP : T_GAP;
  localparam int unsigned CW     = $clog2(MAX_T + 1);
  localparam logic [3:0]  CMD_IDX  = 4'd9;
  localparam logic [7:0]  CMD_ADDR = 8'hF0;

  typedef enum logic [3:0] {
    S_GAP, S_START, S_A_SU, S_A_STB, S_A_HLD,
    S_D_SU, S_D_STB, S_D_HLD, S_CS_OFF, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]      r_mode, w_mode_nxt;
  logic [3:0]      r_txn, w_txn_nxt;
  logic [3:0]      r_idx, w_idx_nxt;
  logic [7:0]      r_ad_out, w_ad_out_nxt;
  logic [7:0]      r_rd_data, w_rd_data_nxt;
  logic [3:0]      r_rd_idx, w_rd_idx_nxt;
  logic            r_rd_valid, w_rd_valid_nxt;
  logic            r_cs_n, r_rd_n, r_wr_n, r_ad, r_ad_oe, r_busy, r_frame_done;
  logic            w_cs_n_nxt, w_rd_n_nxt, w_wr_n_nxt, w_ad_nxt, w_ad_oe_nxt;
  logic            w_busy_nxt, w_frame_done_nxt;
  logic            w_last, w_rd_cur, w_rd_nxt;
  logic [7:0]      w_wdata;

  // Read mode puts the latch command first; other modes put the commit command last.
  function automatic logic [3:0] idx_of(input logic [1:0] mode, input logic [3:0] txn);
    if (mode == 2'b01) return (txn == 4'd0) ? CMD_IDX : (txn - 4'd1);
    return txn;
  endfunction

  function automatic logic [7:0] addr_of(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h41;
      4'd7:    return 8'h42;
      4'd8:    return 8'h43;
      default: return CMD_ADDR;
    endcase
  endfunction

  assign w_last   = (r_cnt == CW'(1));
  assign w_rd_cur = (r_mode == 2'b01) && (r_txn != 4'd0);
  assign w_wdata  = (r_idx == CMD_IDX) ? ((r_mode == 2'b01) ? 8'hF0 : 8'hF1)
                  : ((r_mode == 2'b00) ? 8'h00 : data_in);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_mode_nxt     = r_mode;
    w_txn_nxt      = r_txn;
    w_idx_nxt      = r_idx;
    w_ad_out_nxt   = r_ad_out;
    w_rd_data_nxt  = r_rd_data;
    w_rd_idx_nxt   = r_rd_idx;
    w_rd_valid_nxt = 1'b0;
    if (!w_last) w_cnt_nxt = r_cnt - CW'(1);

    case (r_state)
      S_GAP: if (w_last) w_state_nxt = S_START;
      S_START: begin
        w_mode_nxt = Control;
        w_txn_nxt  = 4'd0;
        if (Control == 2'b11) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt  = S_A_SU;
          w_cnt_nxt    = CW'(T_SU);
          w_idx_nxt    = idx_of(Control, 4'd0);
          w_ad_out_nxt = addr_of(idx_of(Control, 4'd0));
        end
      end
      S_A_SU:  if (w_last) begin w_state_nxt = S_A_STB; w_cnt_nxt = CW'(T_PW); end
      S_A_STB: if (w_last) begin w_state_nxt = S_A_HLD; w_cnt_nxt = CW'(T_SU); end
      S_A_HLD: if (w_last) begin
        w_state_nxt  = S_D_SU;
        w_cnt_nxt    = CW'(T_SU);
        w_ad_out_nxt = w_wdata;
      end
      S_D_SU:  if (w_last) begin w_state_nxt = S_D_STB; w_cnt_nxt = CW'(T_PW); end
      S_D_STB: if (w_last) begin
        w_state_nxt = S_D_HLD;
        w_cnt_nxt   = CW'(T_SU);
        if (w_rd_cur) begin
          w_rd_data_nxt  = ad_in;
          w_rd_idx_nxt   = r_idx;
          w_rd_valid_nxt = 1'b1;
        end
      end
      S_D_HLD: if (w_last) begin w_state_nxt = S_CS_OFF; w_cnt_nxt = CW'(T_SU); end
      S_CS_OFF: if (w_last) begin
        if (r_txn == 4'd9) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt  = S_A_SU;
          w_cnt_nxt    = CW'(T_SU);
          w_txn_nxt    = r_txn + 4'd1;
          w_idx_nxt    = idx_of(r_mode, r_txn + 4'd1);
          w_ad_out_nxt = addr_of(idx_of(r_mode, r_txn + 4'd1));
        end
      end
      S_DONE: begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = CW'(T_GAP);
      end
      default: w_state_nxt = S_GAP;
    endcase

    // Bus pins are decoded from the next state so they register alongside it.
    w_rd_nxt         = (w_mode_nxt == 2'b01) && (w_txn_nxt != 4'd0);
    w_cs_n_nxt       = !(w_state_nxt inside {S_A_SU, S_A_STB, S_A_HLD, S_D_SU, S_D_STB, S_D_HLD});
    w_wr_n_nxt       = !((w_state_nxt == S_A_STB) || ((w_state_nxt == S_D_STB) && !w_rd_nxt));
    w_rd_n_nxt       = !((w_state_nxt == S_D_STB) && w_rd_nxt);
    w_ad_nxt         = w_state_nxt inside {S_D_SU, S_D_STB, S_D_HLD};
    w_ad_oe_nxt      = (w_state_nxt inside {S_A_SU, S_A_STB, S_A_HLD}) ||
                       ((w_state_nxt inside {S_D_SU, S_D_STB, S_D_HLD}) && !w_rd_nxt);
    w_busy_nxt       = !(w_state_nxt inside {S_GAP, S_DONE});
    w_frame_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      r_state      <= S_GAP;
      r_cnt        <= CW'(T_GAP);
      r_mode       <= 2'b11;
      r_txn        <= 4'd0;
      r_idx        <= 4'd0;
      r_ad_out     <= 8'h00;
      r_rd_data    <= 8'h00;
      r_rd_idx     <= 4'd0;
      r_rd_valid   <= 1'b0;
      r_cs_n       <= 1'b1;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_ad         <= 1'b0;
      r_ad_oe      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mode       <= w_mode_nxt;
      r_txn        <= w_txn_nxt;
      r_idx        <= w_idx_nxt;
      r_ad_out     <= w_ad_out_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_rd_idx     <= w_rd_idx_nxt;
      r_rd_valid   <= w_rd_valid_nxt;
      r_cs_n       <= w_cs_n_nxt;
      r_rd_n       <= w_rd_n_nxt;
      r_wr_n       <= w_wr_n_nxt;
      r_ad         <= w_ad_nxt;
      r_ad_oe      <= w_ad_oe_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign reg_idx    = r_idx;
  assign ad_out     = r_ad_out;
  assign ad_oe      = r_ad_oe;
  assign ad         = r_ad;
  assign cs_n       = r_cs_n;
  assign rd_n       = r_rd_n;
  assign wr_n       = r_wr_n;
  assign rd_data    = r_rd_data;
  assign rd_idx     = r_rd_idx;
  assign rd_valid   = r_rd_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: expected bus transactions and read
// returns are queued per frame and matched as the bus monitor observes them.
module tb_rtc_bus_sequencer;

  localparam int unsigned T_SU  = 2;
  localparam int unsigned T_PW  = 4;
  localparam int unsigned T_GAP = 8;
  localparam int FRAME_CYC = 10 * (5 * T_SU + 2 * T_PW);

  logic       reloj = 1'b0;
  logic       resetM;
  logic [1:0] Control;
  logic [7:0] data_in, ad_in;
  logic [3:0] reg_idx, rd_idx;
  logic [7:0] ad_out, rd_data;
  logic       ad_oe, ad, cs_n, rd_n, wr_n, rd_valid, busy, frame_done;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] idx;
  } txn_t;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
  } rdv_t;

  txn_t exp_q[$];
  rdv_t rdv_q[$];
  int   n_checks = 0, n_errors = 0;
  int   n_rdv = 0, n_cs_fall = 0;
  logic [7:0] cur_addr;

  rtc_bus_sequencer #(.T_SU(T_SU), .T_PW(T_PW), .T_GAP(T_GAP)) dut (
    .reloj(reloj), .resetM(resetM), .Control(Control), .data_in(data_in),
    .ad_in(ad_in), .reg_idx(reg_idx), .ad_out(ad_out), .ad_oe(ad_oe), .ad(ad),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .rd_data(rd_data), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .busy(busy), .frame_done(frame_done)
  );

  always #5 reloj = ~reloj;

  // The register bank supplies a byte that encodes the requested index.
  assign data_in = 8'h30 + {4'h0, reg_idx};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] reg_addr(input int i);
    logic [7:0] tbl [9];
    tbl = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    return tbl[i];
  endfunction

  task automatic push_frame(input logic [1:0] mode);
    if (mode == 2'b01) begin
      exp_q.push_back('{1'b0, 8'hF0, 8'hF0, 4'd9});
      for (int i = 0; i < 9; i++) begin
        exp_q.push_back('{1'b1, reg_addr(i), 8'h00, 4'(i)});
        rdv_q.push_back('{4'(i), 8'h5A});
      end
    end else if (mode != 2'b11) begin
      for (int i = 0; i < 9; i++)
        exp_q.push_back('{1'b0, reg_addr(i), (mode == 2'b10) ? 8'(8'h30 + i) : 8'h00, 4'(i)});
      exp_q.push_back('{1'b0, 8'hF0, 8'hF1, 4'd9});
    end
  endtask

  task automatic pop_cmp(input logic is_rd);
    txn_t e;
    if (exp_q.size() == 0) begin
      check_eq("txn_unexpected", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("txn_kind", 32'(is_rd), 32'(e.rd));
      check_eq("txn_addr", 32'(cur_addr), 32'(e.addr));
      check_eq("txn_reg_idx", 32'(reg_idx), 32'(e.idx));
      if (!is_rd) check_eq("txn_wdata", 32'(ad_out), 32'(e.data));
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  logic p_cs_n = 1'b1, p_wr_n = 1'b1, p_rd_n = 1'b1;
  int   cs_run = 0, wr_run = 0, rd_run = 0;
  always @(negedge reloj) begin
    if (resetM !== 1'b1) begin
      p_cs_n = 1'b1; p_wr_n = 1'b1; p_rd_n = 1'b1;
      cs_run = 0; wr_run = 0; rd_run = 0;
    end else begin
      if (!cs_n) cs_run++;
      if (!wr_n) wr_run++;
      if (!rd_n) rd_run++;
      if (!cs_n && p_cs_n) n_cs_fall++;
      if (cs_n && !p_cs_n) begin
        check_eq("cs_low_width", 32'(cs_run), 32'(4 * T_SU + 2 * T_PW));
        cs_run = 0;
      end
      if (wr_n && !p_wr_n) begin check_eq("wr_width", 32'(wr_run), 32'(T_PW)); wr_run = 0; end
      if (rd_n && !p_rd_n) begin check_eq("rd_width", 32'(rd_run), 32'(T_PW)); rd_run = 0; end
      if (!wr_n && p_wr_n) begin
        if (!ad) cur_addr = ad_out;
        else begin
          check_eq("wr_data_oe", 32'(ad_oe), 32'd1);
          pop_cmp(1'b0);
        end
      end
      if (!rd_n) begin
        check_eq("rd_oe_off", 32'(ad_oe), 32'd0);
        check_eq("rd_wr_excl", 32'(wr_n), 32'd1);
      end
      if (!rd_n && p_rd_n) pop_cmp(1'b1);
      if (rd_valid) begin
        rdv_t r;
        n_rdv++;
        if (rdv_q.size() == 0) check_eq("rdv_unexpected", 32'(rdv_q.size()), 32'd1);
        else begin
          r = rdv_q.pop_front();
          check_eq("rdv_idx", 32'(rd_idx), 32'(r.idx));
          check_eq("rdv_data", 32'(rd_data), 32'(r.data));
        end
      end
      p_cs_n = cs_n; p_wr_n = wr_n; p_rd_n = rd_n;
    end
  end

  task automatic wait_cs_fall(output int n);
    n = 0;
    do begin @(posedge reloj); #1; n++; end while (cs_n !== 1'b0 && n < 2000);
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    do begin
      @(posedge reloj); #1; n++;
      if (busy === 1'b1) nb++;
    end while (frame_done !== 1'b1 && n < 2000);
  endtask

  // Runs to frame_done, optionally changing Control part way through the frame.
  task automatic run_frame(input int sw_at, input logic [1:0] sw_mode, output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 2000) begin
      @(posedge reloj); #1; n++;
      if (n == sw_at) begin Control = sw_mode; push_frame(sw_mode); end
    end
    check_eq("done_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, nb, cs0;
    resetM = 1'b0; Control = 2'b01; ad_in = 8'h5A;
    push_frame(2'b01);
    repeat (3) @(negedge reloj);
    check_eq("rst_cs_n", 32'(cs_n), 32'd1);
    check_eq("rst_rd_n", 32'(rd_n), 32'd1);
    check_eq("rst_wr_n", 32'(wr_n), 32'd1);
    check_eq("rst_ad", 32'(ad), 32'd0);
    check_eq("rst_ad_oe", 32'(ad_oe), 32'd0);
    check_eq("rst_ad_out", 32'(ad_out), 32'd0);
    check_eq("rst_reg_idx", 32'(reg_idx), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_rd_idx", 32'(rd_idx), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    resetM = 1'b1;

    // Read frame; Control moves to write mid-frame.
    wait_cs_fall(n);
    check_eq("first_cs_fall", 32'(n), 32'(T_GAP + 1));
    n_rdv = 0;
    run_frame(50, 2'b10, n);
    check_eq("read_frame_len", 32'(n), 32'(FRAME_CYC));
    check_eq("read_rdv_count", 32'(n_rdv), 32'd9);

    // Write frame; Control moves to init mid-frame.
    n_rdv = 0;
    wait_cs_fall(n);
    check_eq("gap_to_write", 32'(n), 32'(T_GAP + 2));
    run_frame(60, 2'b00, n);
    check_eq("write_frame_len", 32'(n), 32'(FRAME_CYC));
    check_eq("write_no_rdv", 32'(n_rdv), 32'd0);

    // Init frame; Control moves to mode-select mid-frame.
    wait_cs_fall(n);
    check_eq("gap_to_init", 32'(n), 32'(T_GAP + 2));
    run_frame(70, 2'b11, n);
    check_eq("init_frame_len", 32'(n), 32'(FRAME_CYC));

    // Mode-select frames: no bus activity, short period.
    cs0 = n_cs_fall;
    for (int k = 0; k < 3; k++) begin
      wait_done(n, nb);
      check_eq("idle_period", 32'(n), 32'(T_GAP + 2));
      check_eq("idle_busy_cycles", 32'(nb), 32'd1);
    end
    check_eq("idle_no_cs", 32'(n_cs_fall - cs0), 32'd0);

    // Read frame interrupted by reset during the first read strobe.
    Control = 2'b01;
    push_frame(2'b01);
    n = 0;
    do begin @(posedge reloj); #1; n++; end while (rd_n !== 1'b0 && n < 2000);
    check_eq("rd_strobe_seen", 32'(rd_n), 32'd0);
    #2 resetM = 1'b0;
    #1;
    check_eq("async_rd_n", 32'(rd_n), 32'd1);
    check_eq("async_cs_n", 32'(cs_n), 32'd1);
    check_eq("async_ad_oe", 32'(ad_oe), 32'd0);
    exp_q.delete();
    rdv_q.delete();
    repeat (3) @(negedge reloj);
    check_eq("rst_no_rdv", 32'(rd_valid), 32'd0);
    resetM = 1'b1;
    push_frame(2'b01);
    n_rdv = 0;
    wait_cs_fall(n);
    check_eq("restart_cs_fall", 32'(n), 32'(T_GAP + 1));
    run_frame(0, 2'b01, n);
    check_eq("restart_frame_len", 32'(n), 32'(FRAME_CYC));
    check_eq("restart_rdv_count", 32'(n_rdv), 32'd9);

    repeat (2) @(negedge reloj);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("rdv_q_empty", 32'(rdv_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
